amm_mem_responder: RTL and testbench

Avalon-MM slave memory model that sits opposite the tester's master and measure logic, answering its read/write traffic with pipelined, burst-capable responses at a fixed read latency. It stores write data in an internal word-addressed RAM and returns it on reads. It exercises the outstanding-read, delay and throughput paths of the checker without external memory.

---
 rtl/amm_mem_responder_pkg.sv | 26 ++
 rtl/rtl_settings_pkg.sv | 14 +
 rtl/amm_rd_cmd_fifo.sv | 73 +++++++
 rtl/amm_mem_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_amm_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/amm_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// amm_mem_responder_pkg
// Types and defaults for the Avalon-MM memory responder.
//   rd_cmd_t   : queued read command {addr, burstcount, accept_tick}
//   rd_state_t : read engine state
//   RESP_RD_LATENCY : default command-to-first-beat latency
// ----------------------------------------------------------------------------
package amm_mem_responder_pkg;

    import rtl_settings_pkg::*;

    localparam int RESP_RD_LATENCY = 4;
    localparam int TICK_W          = 8;

    typedef struct packed {
        logic [ADDR_W-1:0]      addr;
        logic [AMM_BURST_W-1:0] burstcount;
        logic [TICK_W-1:0]      accept_tick;
    } rd_cmd_t;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_BURST = 1'b1
    } rd_state_t;

endpackage

// File: rtl/rtl_settings_pkg.sv
// ----------------------------------------------------------------------------
// rtl_settings_pkg
// Project-wide bus sizing constants shared by the tester blocks.
//   DATA_B_W    : Avalon-MM data bus width in bytes
//   AMM_BURST_W : Avalon-MM burstcount width
//   ADDR_W      : Avalon-MM word address width
// ----------------------------------------------------------------------------
package rtl_settings_pkg;

    localparam int DATA_B_W    = 4;
    localparam int AMM_BURST_W = 4;
    localparam int ADDR_W      = 16;

endpackage

// File: rtl/amm_rd_cmd_fifo.sv
// ----------------------------------------------------------------------------
// amm_rd_cmd_fifo
// Show-ahead FIFO of read commands; o_data always presents the head entry.
// DEPTH must be a power of two (pointers wrap naturally).
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   i_push, i_data    : write an entry (ignored when full)
//   i_pop             : drop the head entry (ignored when empty)
//   o_data            : head entry
//   o_full, o_empty   : occupancy flags
//   o_usedw           : number of stored entries
// ----------------------------------------------------------------------------
module amm_rd_cmd_fifo
    import amm_mem_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      i_push,
    input  rd_cmd_t                   i_data,
    input  logic                      i_pop,
    output rd_cmd_t                   o_data,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_usedw
);

    localparam int PTR_W = $clog2(DEPTH);

    rd_cmd_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == {(PTR_W+1){1'b0}});
    assign o_usedw   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Entry storage; contents need no reset since r_count gates visibility.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {(PTR_W+1){1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1'b1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1'b1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/amm_mem_responder.sv
// ----------------------------------------------------------------------------
// amm_mem_responder
// Avalon-MM slave memory model: stores write bursts in an internal
// word-addressed RAM and answers read bursts at a fixed latency with
// gap-free pipelined beats.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   address_i             : word address (low MEM_AW bits used)
//   read_i, write_i       : read command / write beat
//   writedata_i           : write data
//   byteenable_i          : per-byte write enable
//   burstcount_i          : burst length, sampled on first beat/command
//   waitrequest_o         : read command not accepted this cycle
//   readdata_o            : read data
//   readdatavalid_o       : read beat valid
//   rd_pending_o          : queued plus active read commands
// ----------------------------------------------------------------------------
module amm_mem_responder
    import rtl_settings_pkg::*;
    import amm_mem_responder_pkg::*;
#(
    parameter int DATA_W     = DATA_B_W * 8,
    parameter int BURST_W    = AMM_BURST_W,
    parameter int MEM_AW     = 10,
    parameter int RD_LATENCY = RESP_RD_LATENCY,
    parameter int MAX_OUTST  = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [ADDR_W-1:0]           address_i,
    input  logic                        read_i,
    input  logic                        write_i,
    input  logic [DATA_W-1:0]           writedata_i,
    input  logic [DATA_W/8-1:0]         byteenable_i,
    input  logic [BURST_W-1:0]          burstcount_i,
    output logic                        waitrequest_o,
    output logic [DATA_W-1:0]           readdata_o,
    output logic                        readdatavalid_o,
    output logic [$clog2(MAX_OUTST):0]  rd_pending_o
);

    localparam int BE_W      = DATA_W / 8;
    localparam int PEND_W    = $clog2(MAX_OUTST) + 1;
    localparam int MEM_WORDS = 1 << MEM_AW;

    // A burstcount of zero means a single beat.
    function automatic logic [BURST_W-1:0] burst_beats(input logic [BURST_W-1:0] bc);
        return (bc == {BURST_W{1'b0}}) ? BURST_W'(1'b1) : bc;
    endfunction

    logic [DATA_W-1:0]  r_mem [MEM_WORDS];

    // Write side
    logic               r_wr_active;
    logic [MEM_AW-1:0]  r_wr_addr;
    logic [BURST_W-1:0] r_wr_left;
    logic [MEM_AW-1:0]  w_wr_addr;
    logic [BURST_W-1:0] w_wr_beats;

    // Read side
    rd_state_t          r_state;
    rd_state_t          w_state_nxt;
    logic [MEM_AW-1:0]  r_rd_addr;
    logic [BURST_W-1:0] r_rd_left;
    logic [MEM_AW-1:0]  w_rd_addr_nxt;
    logic [BURST_W-1:0] w_rd_left_nxt;
    logic [MEM_AW-1:0]  w_issue_addr;
    logic               w_issue;
    logic               w_pop;
    logic [TICK_W-1:0]  r_tick;
    logic [TICK_W-1:0]  w_age;
    logic               w_head_ready;
    logic [BURST_W-1:0] w_head_beats;
    logic               r_rdv;
    logic [DATA_W-1:0]  r_rdata;

    // Command queue
    rd_cmd_t            w_push_data;
    rd_cmd_t            w_head;
    logic               w_rd_acc;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [PEND_W-1:0]  w_usedw;
    logic [PEND_W-1:0]  w_pending;
    logic               w_rd_block;
    logic               w_unused_addr_hi;

    // Pending = queued commands plus the one the engine is still bursting.
    assign w_pending = w_usedw + {{(PEND_W-1){1'b0}}, (r_state == RD_BURST)};

    // Reads stall while the outstanding limit is reached, while a write burst
    // is open, or when a write beat is presented in the same cycle. Write
    // beats themselves are always taken.
    assign w_rd_block    = (w_pending == PEND_W'(MAX_OUTST)) | w_fifo_full;
    assign waitrequest_o = read_i & (w_rd_block | r_wr_active | write_i);
    assign w_rd_acc      = read_i & ~waitrequest_o;

    assign readdata_o      = r_rdata;
    assign readdatavalid_o = r_rdv;
    assign rd_pending_o    = w_pending;

    assign w_unused_addr_hi = ^w_head.addr[ADDR_W-1:MEM_AW];

    // Queue entry for an accepted read.
    always_comb begin
        w_push_data             = '{default: 1'b0};
        w_push_data.addr        = address_i;
        w_push_data.burstcount  = burstcount_i;
        w_push_data.accept_tick = r_tick;
    end

    amm_rd_cmd_fifo #(
        .DEPTH   (MAX_OUTST)
    ) u_rd_cmd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_rd_acc),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_usedw (w_usedw)
    );

    // Write address: first beat uses the bus address, later beats advance.
    always_comb begin
        w_wr_beats = burst_beats(burstcount_i);
        w_wr_addr  = r_wr_active ? (r_wr_addr + MEM_AW'(1'b1)) : address_i[MEM_AW-1:0];
    end

    // Write burst tracking; r_wr_addr holds the last word written.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_active <= 1'b0;
            r_wr_addr   <= {MEM_AW{1'b0}};
            r_wr_left   <= {BURST_W{1'b0}};
        end else if (write_i) begin
            r_wr_addr <= w_wr_addr;
            if (!r_wr_active) begin
                r_wr_left   <= w_wr_beats - BURST_W'(1'b1);
                r_wr_active <= (w_wr_beats != BURST_W'(1'b1));
            end else begin
                r_wr_left   <= r_wr_left - BURST_W'(1'b1);
                r_wr_active <= (r_wr_left != BURST_W'(1'b1));
            end
        end else begin
            r_wr_active <= r_wr_active;
        end
    end

    // Byte-enabled RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (write_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (byteenable_i[b]) begin
                    r_mem[w_wr_addr][b*8 +: 8] <= writedata_i[b*8 +: 8];
                end
            end
        end
    end

    // Head eligibility: age is taken modulo 256 so the tick may wrap freely.
    // The first beat issues in the cycle the head is popped, so an age of
    // RD_LATENCY-1 yields data RD_LATENCY cycles after acceptance.
    always_comb begin
        w_age        = r_tick - w_head.accept_tick;
        w_head_beats = burst_beats(w_head.burstcount);
        w_head_ready = ~w_fifo_empty & (w_age >= TICK_W'(RD_LATENCY - 1));
    end

    // Read engine next-state: IDLE issues the head's first beat on pop; a
    // following eligible head is picked up straight from IDLE, so bursts
    // chain without bubbles.
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_issue       = 1'b0;
        w_issue_addr  = r_rd_addr;
        w_rd_addr_nxt = r_rd_addr;
        w_rd_left_nxt = r_rd_left;
        case (r_state)
            RD_IDLE: begin
                if (w_head_ready) begin
                    w_pop         = 1'b1;
                    w_issue       = 1'b1;
                    w_issue_addr  = w_head.addr[MEM_AW-1:0];
                    w_rd_addr_nxt = w_head.addr[MEM_AW-1:0] + MEM_AW'(1'b1);
                    w_rd_left_nxt = w_head_beats - BURST_W'(1'b1);
                    w_state_nxt   = (w_head_beats == BURST_W'(1'b1)) ? RD_IDLE : RD_BURST;
                end else begin
                    w_state_nxt   = RD_IDLE;
                end
            end
            RD_BURST: begin
                w_issue       = 1'b1;
                w_rd_addr_nxt = r_rd_addr + MEM_AW'(1'b1);
                w_rd_left_nxt = r_rd_left - BURST_W'(1'b1);
                w_state_nxt   = (r_rd_left == BURST_W'(1'b1)) ? RD_IDLE : RD_BURST;
            end
            default: begin
                w_state_nxt   = RD_IDLE;
            end
        endcase
    end

    // Read engine state, burst counters and the free-running tick.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= RD_IDLE;
            r_rd_addr <= {MEM_AW{1'b0}};
            r_rd_left <= {BURST_W{1'b0}};
            r_tick    <= {TICK_W{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_rd_left <= w_rd_left_nxt;
            r_tick    <= r_tick + TICK_W'(1'b1);
        end
    end

    // Registered RAM read port: issue in cycle N returns data in N+1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdv   <= 1'b0;
            r_rdata <= {DATA_W{1'b0}};
        end else begin
            r_rdv <= w_issue;
            if (w_issue) begin
                r_rdata <= r_mem[w_issue_addr];
            end else begin
                r_rdata <= r_rdata;
            end
        end
    end

endmodule

// File: tb/tb_amm_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_amm_mem_responder
// Directed self-checking bench for amm_mem_responder with default parameters
// (32-bit data, 4-bit burstcount, 1024-word RAM, read latency 4, 4 outstanding).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_amm_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] address_i;
    logic        read_i;
    logic        write_i;
    logic [31:0] writedata_i;
    logic [3:0]  byteenable_i;
    logic [3:0]  burstcount_i;
    logic        waitrequest_o;
    logic [31:0] readdata_o;
    logic        readdatavalid_o;
    logic [2:0]  rd_pending_o;

    int n_vec = 0;
    int n_err = 0;

    logic        cap_v [32];
    logic [31:0] cap_d [32];
    logic [2:0]  cap_p [32];

    amm_mem_responder dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .address_i       (address_i),
        .read_i          (read_i),
        .write_i         (write_i),
        .writedata_i     (writedata_i),
        .byteenable_i    (byteenable_i),
        .burstcount_i    (burstcount_i),
        .waitrequest_o   (waitrequest_o),
        .readdata_o      (readdata_o),
        .readdatavalid_o (readdatavalid_o),
        .rd_pending_o    (rd_pending_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Write burst of n beats, data base+i; later beats carry junk address/burstcount.
    task automatic wr_burst(input logic [15:0] addr, input int n, input logic [31:0] base, input logic [3:0] be);
        logic [3:0] bc;
        bc = n[3:0];
        for (int i = 0; i < n; i++) begin
            write_i      = 1'b1;
            address_i    = (i == 0) ? addr : 16'h0F0F;
            burstcount_i = (i == 0) ? bc : 4'hF;
            writedata_i  = base + 32'(i);
            byteenable_i = be;
            tick();
        end
        write_i = 1'b0;
    endtask

    // Present a read until accepted; returns in the cycle after acceptance.
    task automatic rd_issue(input logic [15:0] addr, input logic [3:0] bc);
        int guard;
        guard        = 0;
        read_i       = 1'b1;
        address_i    = addr;
        burstcount_i = bc;
        #4;
        while (waitrequest_o === 1'b1 && guard < 40) begin
            tick();
            #4;
            guard++;
        end
        if (guard >= 40) begin
            n_vec++;
            n_err++;
            $display("FAIL rd_issue_timeout: waitrequest still %b after %0d cycles, required 0", waitrequest_o, guard);
        end
        @(posedge clk_i);
        #1;
        read_i = 1'b0;
    endtask

    // Record outputs for n cycles, index 0 = current cycle.
    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            #4;
            cap_v[k] = readdatavalid_o;
            cap_d[k] = readdata_o;
            cap_p[k] = rd_pending_o;
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = 16'h0;
        writedata_i = 32'h0; byteenable_i = 4'hF; burstcount_i = 4'h1;
        repeat (2) @(posedge clk_i);
        #5;
        n_vec++; if (waitrequest_o !== 1'b0) begin n_err++; $display("FAIL reset_waitrequest: got %b required 0", waitrequest_o); end
        n_vec++; if (readdatavalid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", readdatavalid_o); end
        n_vec++; if (readdata_o !== 32'h0) begin n_err++; $display("FAIL reset_readdata: got %h required 00000000", readdata_o); end
        n_vec++; if (rd_pending_o !== 3'd0) begin n_err++; $display("FAIL reset_pending: got %0d required 0", rd_pending_o); end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int nb;
        wr_burst(16'd5, 1, 32'hA5A5_0001, 4'hF);
        rd_issue(16'd5, 4'd1);
        capture(8);
        nb = 0;
        for (int k = 0; k < 8; k++) nb += (cap_v[k] === 1'b1) ? 1 : 0;
        n_vec++; if (cap_p[0] !== 3'd1) begin n_err++; $display("FAIL single_pending_after_accept: got %0d required 1", cap_p[0]); end
        n_vec++; if (cap_v[3] !== 1'b1 || nb != 1) begin n_err++; $display("FAIL single_latency: valid@T+4=%b beats=%0d required 1 and 1", cap_v[3], nb); end
        n_vec++; if (cap_d[3] !== 32'hA5A5_0001) begin n_err++; $display("FAIL single_data: got %h required a5a50001", cap_d[3]); end
        n_vec++; if (cap_p[3] !== 3'd0) begin n_err++; $display("FAIL single_pending_done: got %0d required 0", cap_p[3]); end
        // burstcount 0 counts as a single beat
        rd_issue(16'd5, 4'd0);
        capture(10);
        nb = 0;
        for (int k = 0; k < 10; k++) nb += (cap_v[k] === 1'b1) ? 1 : 0;
        n_vec++; if (nb != 1 || cap_d[3] !== 32'hA5A5_0001) begin n_err++; $display("FAIL burst0_single_beat: beats=%0d data=%h required 1 a5a50001", nb, cap_d[3]); end
    endtask

    task automatic test_burst_wrap();
        logic expv;
        wr_burst(16'd1020, 8, 32'hB000_0000, 4'hF);
        rd_issue(16'd1020, 4'd8);
        capture(14);
        for (int k = 0; k < 14; k++) begin
            expv = (k >= 3 && k <= 10);
            n_vec++;
            if (cap_v[k] !== expv || (expv && cap_d[k] !== 32'hB000_0000 + 32'(k - 3))) begin
                n_err++;
                $display("FAIL burst_wrap_beat%0d: valid=%b data=%h required valid=%b data=%h", k, cap_v[k], cap_d[k], expv, 32'hB000_0000 + 32'(k - 3));
            end
        end
        // fifth written word must have landed at address 0
        rd_issue(16'd0, 4'd1);
        capture(6);
        n_vec++; if (cap_v[3] !== 1'b1 || cap_d[3] !== 32'hB000_0004) begin n_err++; $display("FAIL wrap_addr0: valid=%b data=%h required 1 b0000004", cap_v[3], cap_d[3]); end
    endtask

    task automatic test_byteenable();
        wr_burst(16'd50, 1, 32'hFFFF_FFFF, 4'hF);
        wr_burst(16'd50, 1, 32'h1234_5678, 4'b0101);
        rd_issue(16'd50, 4'd1);
        capture(6);
        n_vec++; if (cap_v[3] !== 1'b1 || cap_d[3] !== 32'hFF34_FF78) begin n_err++; $display("FAIL byteenable: valid=%b data=%h required 1 ff34ff78", cap_v[3], cap_d[3]); end
    endtask

    task automatic test_queue_full();
        int n_acc, acc5, first_v, last_v, n_beats, derr;
        logic w5;
        logic [2:0] p5;
        n_acc = 0; acc5 = -1; first_v = -1; last_v = -1; n_beats = 0; derr = 0;
        w5 = 1'b0; p5 = 3'd0;
        wr_burst(16'd100, 10, 32'hC000_0064, 4'hF);
        wr_burst(16'd110, 10, 32'hC000_006E, 4'hF);
        for (int c = 0; c < 30; c++) begin
            if (n_acc < 5) begin
                read_i = 1'b1; address_i = 16'(100 + 4 * n_acc); burstcount_i = 4'd4;
            end else begin
                read_i = 1'b0;
            end
            #4;
            if (c == 5) begin w5 = waitrequest_o; p5 = rd_pending_o; end
            if (read_i && !waitrequest_o) begin
                if (n_acc == 4) acc5 = c;
                n_acc++;
            end
            if (readdatavalid_o === 1'b1) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                if (readdata_o !== 32'hC000_0064 + 32'(n_beats)) derr++;
                n_beats++;
            end
            @(posedge clk_i);
            #1;
        end
        read_i = 1'b0;
        n_vec++; if (w5 !== 1'b1) begin n_err++; $display("FAIL qfull_waitrequest: got %b required 1", w5); end
        n_vec++; if (p5 !== 3'd4) begin n_err++; $display("FAIL qfull_pending: got %0d required 4", p5); end
        n_vec++; if (acc5 != 7) begin n_err++; $display("FAIL qfull_fifth_accept: cycle %0d required 7", acc5); end
        n_vec++; if (n_beats != 20 || first_v != 4 || last_v != 23) begin n_err++; $display("FAIL qfull_stream: beats=%0d first=%0d last=%0d required 20 4 23", n_beats, first_v, last_v); end
        n_vec++; if (derr != 0) begin n_err++; $display("FAIL qfull_data: %0d wrong beats required 0", derr); end
    endtask

    task automatic test_conflict();
        logic racc, w0, w2, w4, w5;
        int racc_c, first_v, n_beats, derr, beat;
        racc = 1'b0; racc_c = -1; first_v = -1; n_beats = 0; derr = 0; beat = 0;
        w0 = 1'b0; w2 = 1'b0; w4 = 1'b0; w5 = 1'b1;
        address_i = 16'd200; burstcount_i = 4'd4; byteenable_i = 4'hF;
        for (int c = 0; c < 17; c++) begin
            write_i = (c == 0 || c == 1 || c == 3 || c == 4);
            writedata_i = 32'hD000_0000 + 32'(beat);
            read_i = ~racc;
            #4;
            if (c == 0) w0 = waitrequest_o;
            if (c == 2) w2 = waitrequest_o;
            if (c == 4) w4 = waitrequest_o;
            if (c == 5) w5 = waitrequest_o;
            if (read_i && !waitrequest_o) begin racc = 1'b1; racc_c = c; end
            if (write_i) beat++;
            if (readdatavalid_o === 1'b1) begin
                if (first_v < 0) first_v = c;
                if (readdata_o !== 32'hD000_0000 + 32'(n_beats)) derr++;
                n_beats++;
            end
            @(posedge clk_i);
            #1;
        end
        read_i = 1'b0; write_i = 1'b0;
        n_vec++; if (w0 !== 1'b1) begin n_err++; $display("FAIL conflict_same_cycle_wait: got %b required 1", w0); end
        n_vec++; if (w2 !== 1'b1 || w4 !== 1'b1) begin n_err++; $display("FAIL conflict_burst_wait: c2=%b c4=%b required 1 1", w2, w4); end
        n_vec++; if (w5 !== 1'b0 || racc_c != 5) begin n_err++; $display("FAIL conflict_release: wait=%b accept_cycle=%0d required 0 5", w5, racc_c); end
        n_vec++; if (first_v != 9 || n_beats != 4 || derr != 0) begin n_err++; $display("FAIL conflict_read_back: first=%0d beats=%0d bad=%0d required 9 4 0", first_v, n_beats, derr); end
        // simultaneous single read and write: only the write is taken
        read_i = 1'b1; write_i = 1'b1; address_i = 16'd300; burstcount_i = 4'd1;
        writedata_i = 32'h0BAD_F00D; byteenable_i = 4'hF;
        #4;
        n_vec++; if (waitrequest_o !== 1'b1) begin n_err++; $display("FAIL simul_waitrequest: got %b required 1", waitrequest_o); end
        @(posedge clk_i);
        #1;
        read_i = 1'b0; write_i = 1'b0;
        capture(8);
        begin
            int nv, np;
            nv = 0; np = 0;
            for (int k = 0; k < 8; k++) begin
                nv += (cap_v[k] !== 1'b0) ? 1 : 0;
                np += (cap_p[k] !== 3'd0) ? 1 : 0;
            end
            n_vec++; if (nv != 0 || np != 0) begin n_err++; $display("FAIL simul_no_read: valid_cycles=%0d pending_cycles=%0d required 0 0", nv, np); end
        end
        rd_issue(16'd300, 4'd1);
        capture(6);
        n_vec++; if (cap_v[3] !== 1'b1 || cap_d[3] !== 32'h0BAD_F00D) begin n_err++; $display("FAIL simul_write_taken: valid=%b data=%h required 1 0badf00d", cap_v[3], cap_d[3]); end
    endtask

    task automatic test_reset_mid();
        int nv, np;
        rd_issue(16'd0, 4'd8);
        repeat (5) tick();
        #4;
        n_vec++; if (readdatavalid_o !== 1'b1) begin n_err++; $display("FAIL midrst_third_beat: valid=%b required 1", readdatavalid_o); end
        #1;
        rst_i = 1'b1;
        #1;
        n_vec++; if (readdatavalid_o !== 1'b0 || rd_pending_o !== 3'd0) begin n_err++; $display("FAIL midrst_immediate: valid=%b pending=%0d required 0 0", readdatavalid_o, rd_pending_o); end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        capture(14);
        nv = 0; np = 0;
        for (int k = 0; k < 14; k++) begin
            nv += (cap_v[k] !== 1'b0) ? 1 : 0;
            np += (cap_p[k] !== 3'd0) ? 1 : 0;
        end
        n_vec++; if (nv != 0 || np != 0) begin n_err++; $display("FAIL midrst_no_beats: valid_cycles=%0d pending_cycles=%0d required 0 0", nv, np); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_wrap();
        test_byteenable();
        test_queue_full();
        test_conflict();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
